// File: rtl/mod31_pkg.sv
// Shared constants, FSM state type and end-around-carry adder for the mod-31 residue path.
package mod31_pkg;

  localparam int WORD_W     = 64;
  localparam int RES_W      = 5;
  localparam int WEIGHT_ROT = 4;   // 2^64 mod 31 = 16 = rotate-left by 4 in 5 bits

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef logic [RES_W-1:0] res_t;

  // Ones'-complement style add: carry out wraps to bit 0, and 31 (the second zero) folds to 0.
  function automatic res_t mod31_add5(input res_t a, input res_t b);
    logic [RES_W:0] sum;
    res_t           wrapped;
    sum     = {1'b0, a} + {1'b0, b};
    wrapped = sum[RES_W-1:0] + {{(RES_W-1){1'b0}}, sum[RES_W]};
    return (wrapped == '1) ? '0 : wrapped;
  endfunction

endpackage

// File: rtl/mod31_64bit.sv
// Combinational residue of one 64-bit word mod 31, optionally as a two's-complement value.
module mod31_64bit
  import mod31_pkg::*;
(
  input  logic [WORD_W-1:0] data,
  input  logic              sign,
  input  logic [2:0]        pad,
  output res_t              residue
);

  localparam int CHUNKS = 14;
  localparam int EXT_W  = CHUNKS * RES_W;

  logic [EXT_W-1:0] ext;
  logic [8:0]       sum;
  logic [5:0]       fold1;
  logic [4:0]       fold2;

  // Pad to 70 bits so every 5-bit chunk has weight 2^(5k) = 1 mod 31. A negative 70-bit value
  // is unsigned - 2^70, i.e. unsigned - 1 mod 31, hence the +30 correction when sign is set.
  assign ext = {pad, pad, data};

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    sum = sign ? 9'd30 : 9'd0;
    for (int i = 0; i < CHUNKS; i++) begin
      sum = sum + {4'b0, ext[i*RES_W +: RES_W]};
    end
    fold1 = {1'b0, sum[4:0]} + {2'b0, sum[8:5]};
    fold2 = fold1[4:0] + {4'b0, fold1[5]};
    residue = (fold2 == 5'd31) ? '0 : fold2;
  end

endmodule

// File: rtl/mod31_horner_step.sv
// One Horner step for 64-bit digits: acc_next = (acc * 2^64 + r) mod 31.
module mod31_horner_step
  import mod31_pkg::*;
(
  input  res_t acc,
  input  res_t r,
  output res_t acc_next
);

  res_t acc_rot;

  assign acc_rot  = RES_W'((acc << WEIGHT_ROT) | (acc >> (RES_W - WEIGHT_ROT)));
  assign acc_next = mod31_add5(acc_rot, r);

endmodule

// File: rtl/mod31_stream_ctrl.sv
// Streams a multi-word operand (MSB word first) through one word-residue unit and accumulates
// the operand mod 31. Optional residue compare port enabled by defining MOD31_CHECK_EN.
module mod31_stream_ctrl
  import mod31_pkg::*;
#(
  parameter int MAX_WORDS = 8,
  parameter int CNT_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  input  logic              in_signed,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  out_residue,
  output logic              out_err,
  output logic              busy
`ifdef MOD31_CHECK_EN
  ,
  input  logic [RES_W-1:0]  exp_residue,
  output logic              out_mismatch
`endif
);

  state_t           state;
  res_t             acc;
  logic [CNT_W-1:0] cnt;
  logic             err;

  logic             accept;
  logic             first;
  logic             sign;
  res_t             word_res;
  res_t             acc_in;
  res_t             step_res;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W-1:0] word_num;
  logic             err_base;
  logic             err_next;
  res_t             res_next;

  assign in_ready  = (state != DONE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

  assign accept = in_valid & in_ready;
  assign first  = (state == IDLE);

  // Only the most significant word carries the operand sign; later words are pure magnitude.
  assign sign = in_signed & in_data[WORD_W-1] & first;

  mod31_64bit u_word (
    .data    (in_data),
    .sign    (sign),
    .pad     ({3{sign}}),
    .residue (word_res)
  );

  assign acc_in = first ? '0 : acc;

  mod31_horner_step u_step (
    .acc      (acc_in),
    .r        (word_res),
    .acc_next (step_res)
  );

  assign cnt_base = first ? '0 : cnt;
  assign word_num = cnt_base + CNT_W'(1);
  assign err_base = first ? 1'b0 : err;
  assign err_next = err_base | ((word_num == CNT_W'(MAX_WORDS)) & ~in_last);
  assign res_next = err_next ? '0 : step_res;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      err         <= 1'b0;
      out_residue <= '0;
      out_err     <= 1'b0;
`ifdef MOD31_CHECK_EN
      out_mismatch <= 1'b0;
`endif
    end else begin
      // NOTE: all state updates are non-blocking so every register sees pre-edge values.
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            acc <= step_res;
            // Counter freezes once overflow is flagged; discarded words only wait for in_last.
            cnt <= err_base ? cnt_base : word_num;
            err <= err_next;
            if (in_last) begin
              state       <= DONE;
              out_residue <= res_next;
              out_err     <= err_next;
`ifdef MOD31_CHECK_EN
              out_mismatch <= (res_next != exp_residue) | err_next;
`endif
            end else begin
              state <= ACCUM;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
